// File: rtl/l4_pkg.sv
// Shared L4 accelerator constants: command word width and default
// command-queue depth, used by the command FIFO and accelerator control.
package l4_pkg;

  localparam int L4_CMD_W      = 32;
  localparam int L4_FIFO_DBITS = 5;
  localparam int L4_FIFO_DEPTH = 1 << L4_FIFO_DBITS;

endpackage

// File: rtl/l4_fifo_ram.sv
// Command queue storage: synchronous write port, asynchronous read port.
// Contents are never reset; occupancy tracking decides what is valid.
import l4_pkg::*;

module l4_fifo_ram #(
  parameter int AW = L4_FIFO_DBITS,
  parameter int DW = L4_CMD_W
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [2**AW];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/l4_cmd_fifo.sv
// Host-to-accelerator command FIFO: first-word-fall-through head,
// registered occupancy flags, sticky overflow/underflow reporting.
import l4_pkg::*;

module l4_cmd_fifo #(
  parameter int DBITS     = L4_FIFO_DBITS,
  parameter int AF_MARGIN = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [L4_CMD_W-1:0] host_wdata,
  input  logic                host_wr,
  output logic                host_full,
  output logic                host_afull,
  output logic [L4_CMD_W-1:0] cmd_out,
  output logic                cmd_empty,
  input  logic                cmd_rd,
  input  logic                flush,
  input  logic                clr_err,
  output logic [DBITS:0]      count,
  output logic                overflow,
  output logic                underflow
);

  localparam logic [DBITS:0] LP_DEPTH =
    (DBITS+1)'(2**DBITS);
  localparam logic [DBITS:0] LP_AFULL =
    (DBITS+1)'(2**DBITS - AF_MARGIN);

  logic [DBITS-1:0] r_wr_ptr;
  logic [DBITS-1:0] r_rd_ptr;
  logic [DBITS:0]   r_cnt;
  logic             r_full;
  logic             r_afull;
  logic             r_empty;
  logic             r_ovf;
  logic             r_unf;

  logic             w_wr_req;
  logic             w_rd_req;
  logic             w_wr_ok;
  logic             w_rd_ok;
  logic             w_ovf_set;
  logic             w_unf_set;
  logic [DBITS:0]   w_cnt_nxt;
  logic [DBITS-1:0] w_wr_ptr_nxt;
  logic [DBITS-1:0] w_rd_ptr_nxt;

  // Flush swallows both requests so they neither move data nor raise errors.
  assign w_wr_req  = host_wr & ~flush;
  assign w_rd_req  = cmd_rd & ~flush;
  assign w_wr_ok   = w_wr_req & ~r_full;
  assign w_rd_ok   = w_rd_req & ~r_empty;
  assign w_ovf_set = w_wr_req & r_full;
  assign w_unf_set = w_rd_req & r_empty;

  always_comb begin
    w_cnt_nxt    = r_cnt;
    w_wr_ptr_nxt = r_wr_ptr;
    w_rd_ptr_nxt = r_rd_ptr;
    if (flush) begin
      w_cnt_nxt    = '0;
      w_wr_ptr_nxt = '0;
      w_rd_ptr_nxt = '0;
    end else begin
      if (w_wr_ok) begin
        w_wr_ptr_nxt = r_wr_ptr + DBITS'(1);
      end
      if (w_rd_ok) begin
        w_rd_ptr_nxt = r_rd_ptr + DBITS'(1);
      end
      unique case ({w_wr_ok, w_rd_ok})
        2'b10:   w_cnt_nxt = r_cnt + (DBITS+1)'(1);
        2'b01:   w_cnt_nxt = r_cnt - (DBITS+1)'(1);
        default: w_cnt_nxt = r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      r_full   <= 1'b0;
      r_afull  <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_cnt    <= w_cnt_nxt;
      r_full   <= (w_cnt_nxt == LP_DEPTH);
      r_afull  <= (w_cnt_nxt >= LP_AFULL);
      r_empty  <= (w_cnt_nxt == '0);
    end
  end

  // A fresh error event wins over a same-cycle clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end else if (clr_err) begin
        r_ovf <= 1'b0;
      end
      if (w_unf_set) begin
        r_unf <= 1'b1;
      end else if (clr_err) begin
        r_unf <= 1'b0;
      end
    end
  end

  l4_fifo_ram #(
    .AW (DBITS),
    .DW (L4_CMD_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_wr_ok),
    .i_waddr (r_wr_ptr),
    .i_wdata (host_wdata),
    .i_raddr (r_rd_ptr),
    .o_rdata (cmd_out)
  );

  assign host_full  = r_full;
  assign host_afull = r_afull;
  assign cmd_empty  = r_empty;
  assign count      = r_cnt;
  assign overflow   = r_ovf;
  assign underflow  = r_unf;

endmodule

// File: tb/tb_l4_cmd_fifo.sv
// Directed bench for l4_cmd_fifo: fill/drain, boundaries, error
// flags, flush and asynchronous reset behaviour.
module tb_l4_cmd_fifo;

  logic        clk;
  logic        reset;
  logic [31:0] host_wdata;
  logic        host_wr;
  logic        host_full;
  logic        host_afull;
  logic [31:0] cmd_out;
  logic        cmd_empty;
  logic        cmd_rd;
  logic        flush;
  logic        clr_err;
  logic [5:0]  count;
  logic        overflow;
  logic        underflow;

  int n_cmp;
  int n_err;

  l4_cmd_fifo #(
    .DBITS     (5),
    .AF_MARGIN (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .host_wdata (host_wdata),
    .host_wr    (host_wr),
    .host_full  (host_full),
    .host_afull (host_afull),
    .cmd_out    (cmd_out),
    .cmd_empty  (cmd_empty),
    .cmd_rd     (cmd_rd),
    .flush      (flush),
    .clr_err    (clr_err),
    .count      (count),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock with the given controls held, then controls return idle.
  task automatic step(input logic wr, input logic [31:0] d,
                      input logic rd, input logic fl,
                      input logic ce);
    host_wr    = wr;
    host_wdata = d;
    cmd_rd     = rd;
    flush      = fl;
    clr_err    = ce;
    @(posedge clk);
    #1;
    host_wr = 1'b0;
    cmd_rd  = 1'b0;
    flush   = 1'b0;
    clr_err = 1'b0;
  endtask

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    reset      = 1'b0;
    host_wr    = 1'b0;
    host_wdata = '0;
    cmd_rd     = 1'b0;
    flush      = 1'b0;
    clr_err    = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(cmd_empty), 1);
    chk("rst_full", 32'(host_full), 0);
    chk("rst_afull", 32'(host_afull), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_unf", 32'(underflow), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Two back-to-back writes, head falls through after the first
    step(1, 32'h11111111, 0, 0, 0);
    chk("w1_empty", 32'(cmd_empty), 0);
    chk("w1_head", cmd_out, 32'h11111111);
    chk("w1_count", 32'(count), 1);
    step(1, 32'h22222222, 0, 0, 0);
    chk("w2_head", cmd_out, 32'h11111111);
    chk("w2_count", 32'(count), 2);
    step(0, 0, 0, 1, 0);
    chk("fl0_count", 32'(count), 0);
    chk("fl0_empty", 32'(cmd_empty), 1);

    // Fill to full, checking the threshold flags on every write
    for (int i = 0; i < 32; i++) begin
      step(1, 32'(i), 0, 0, 0);
      chk("fill_count", 32'(count), 32'(i + 1));
      chk("fill_afull", 32'(host_afull), 32'((i + 1) >= 28));
      chk("fill_full", 32'(host_full), 32'((i + 1) == 32));
    end
    step(1, 32'hDEADBEEF, 0, 0, 0);
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_count", 32'(count), 32);
    chk("ovf_head", cmd_out, 0);
    for (int i = 0; i < 32; i++) begin
      chk("drain_data", cmd_out, 32'(i));
      step(0, 0, 1, 0, 0);
    end
    chk("drain_empty", 32'(cmd_empty), 1);
    chk("drain_count", 32'(count), 0);
    chk("drain_unf", 32'(underflow), 0);
    step(0, 0, 0, 0, 1);
    chk("clr_ovf", 32'(overflow), 0);

    // Full queue: simultaneous write and pop drops the write
    for (int i = 0; i < 32; i++) begin
      step(1, 32'(100 + i), 0, 0, 0);
    end
    chk("f2_full", 32'(host_full), 1);
    step(1, 32'hCAFEF00D, 1, 0, 0);
    chk("wp_count", 32'(count), 31);
    chk("wp_ovf", 32'(overflow), 1);
    chk("wp_full", 32'(host_full), 0);
    chk("wp_head", cmd_out, 101);
    step(0, 0, 0, 1, 1);
    chk("fc_count", 32'(count), 0);
    chk("fc_ovf", 32'(overflow), 0);

    // Empty queue: pop with write flags underflow, write still lands
    step(1, 32'hA5A5A5A5, 1, 0, 0);
    chk("uw_unf", 32'(underflow), 1);
    chk("uw_count", 32'(count), 1);
    chk("uw_head", cmd_out, 32'hA5A5A5A5);
    step(0, 0, 0, 1, 0);
    chk("uw_fl_unf", 32'(underflow), 1);
    step(0, 0, 1, 0, 1);
    chk("clr_vs_err", 32'(underflow), 1);
    step(0, 0, 0, 0, 1);
    chk("clr_unf", 32'(underflow), 0);
    step(1, 32'h1, 1, 1, 0);
    chk("flrq_count", 32'(count), 0);
    chk("flrq_unf", 32'(underflow), 0);
    chk("flrq_ovf", 32'(overflow), 0);

    // Steady 1-in-1-out at depth 3 across pointer wrap
    for (int j = 0; j < 3; j++) begin
      step(1, 32'(1000 + j), 0, 0, 0);
    end
    for (int k = 0; k < 100; k++) begin
      chk("ss_head", cmd_out, 32'(1000 + k));
      step(1, 32'(1003 + k), 1, 0, 0);
      chk("ss_count", 32'(count), 3);
    end
    chk("ss_ovf", 32'(overflow), 0);
    chk("ss_unf", 32'(underflow), 0);
    step(0, 0, 0, 1, 0);

    // Flush keeps sticky flags; asynchronous reset clears everything
    step(0, 0, 1, 0, 0);
    chk("pre_unf", 32'(underflow), 1);
    for (int i = 0; i < 10; i++) begin
      step(1, 32'(200 + i), 0, 0, 0);
    end
    chk("l10_count", 32'(count), 10);
    step(0, 0, 0, 1, 0);
    chk("fl10_count", 32'(count), 0);
    chk("fl10_empty", 32'(cmd_empty), 1);
    chk("fl10_unf", 32'(underflow), 1);
    for (int i = 0; i < 5; i++) begin
      step(1, 32'(300 + i), 0, 0, 0);
    end
    chk("l5_count", 32'(count), 5);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("ar_count", 32'(count), 0);
    chk("ar_empty", 32'(cmd_empty), 1);
    chk("ar_unf", 32'(underflow), 0);
    @(negedge clk);
    reset = 1'b0;
    step(1, 32'h77777777, 0, 0, 0);
    chk("ar_head", cmd_out, 32'h77777777);
    chk("ar_count1", 32'(count), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
